// File: rtl/dcache_evict_ctrl_pkg.sv
// rtl/dcache_evict_ctrl_pkg.sv - shared dcache geometry and evict/refill FSM state encoding
package dcache_evict_ctrl_pkg;

    localparam int DC_TAG_W = 44;
    localparam int DC_IDX_W = 6;
    localparam int DC_WAYS  = 8;
    localparam int DC_WAY_W = 3;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_LOOKUP  = 4'd1,
        ST_SELECT  = 4'd2,
        ST_WB_REQ  = 4'd3,
        ST_WB_WAIT = 4'd4,
        ST_RF_REQ  = 4'd5,
        ST_RF_WAIT = 4'd6,
        ST_UPDATE  = 4'd7,
        ST_DONE    = 4'd8
    } evict_state_t;

endpackage

// File: rtl/dcache_evict_ctrl.sv
// rtl/dcache_evict_ctrl.sv - single-miss dcache evict/writeback/refill sequencer
module dcache_evict_ctrl
    import dcache_evict_ctrl_pkg::*;
#(
    parameter int TAG_W = DC_TAG_W,
    parameter int IDX_W = DC_IDX_W
) (
    input  logic                        clock,
    input  logic                        reset,

    input  logic                        miss_valid,
    output logic                        miss_ready,
    input  logic [IDX_W-1:0]            miss_index,
    input  logic [TAG_W-1:0]            miss_tag,
    input  logic [DC_WAYS*TAG_W-1:0]    miss_tag_all,

    output logic                        done_valid,
    output logic [DC_WAY_W-1:0]         done_way,

    output logic                        ctrl2replace_valid,
    output logic [IDX_W-1:0]            ctrl2replace_index,
    output logic [DC_WAYS*TAG_W-1:0]    ctrl2replace_tag_all,
    output logic                        ctrl2replace_ready,
    input  logic [DC_WAY_W-1:0]         replace2ctrl_way,
    input  logic                        replace2ctrl_dirty,
    input  logic [TAG_W-1:0]            replace2ctrl_tag,

    output logic                        wb_valid,
    input  logic                        wb_ready,
    output logic [TAG_W+IDX_W-1:0]      wb_addr,
    input  logic                        wb_done,

    output logic                        rf_valid,
    input  logic                        rf_ready,
    output logic [TAG_W+IDX_W-1:0]      rf_addr,
    input  logic                        rf_done,

    output logic                        tag_we,
    output logic [IDX_W-1:0]            tag_wr_index,
    output logic [DC_WAY_W-1:0]         tag_wr_way,
    output logic [TAG_W-1:0]            tag_wr_tag,
    output logic                        dirty_clr
);

    evict_state_t          state;
    logic [IDX_W-1:0]      idx_q;
    logic [TAG_W-1:0]      tag_q;
    logic [DC_WAY_W-1:0]   victim_way;

    // Every output is registered: it is set on the edge that enters the state it belongs to.
    always_ff @(posedge clock) begin
        if (reset) begin
            state                <= ST_IDLE;
            idx_q                <= '0;
            tag_q                <= '0;
            victim_way           <= '0;
            miss_ready           <= 1'b1;
            done_valid           <= 1'b0;
            done_way             <= '0;
            ctrl2replace_valid   <= 1'b0;
            ctrl2replace_index   <= '0;
            ctrl2replace_tag_all <= '0;
            ctrl2replace_ready   <= 1'b0;
            wb_valid             <= 1'b0;
            wb_addr              <= '0;
            rf_valid             <= 1'b0;
            rf_addr              <= '0;
            tag_we               <= 1'b0;
            tag_wr_index         <= '0;
            tag_wr_way           <= '0;
            tag_wr_tag           <= '0;
            dirty_clr            <= 1'b0;
        end else begin
            ctrl2replace_valid <= 1'b0;
            ctrl2replace_ready <= 1'b0;
            tag_we             <= 1'b0;
            dirty_clr          <= 1'b0;
            done_valid         <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (miss_valid && miss_ready) begin
                        idx_q                <= miss_index;
                        tag_q                <= miss_tag;
                        ctrl2replace_index   <= miss_index;
                        ctrl2replace_tag_all <= miss_tag_all;
                        ctrl2replace_valid   <= 1'b1;
                        miss_ready           <= 1'b0;
                        state                <= ST_LOOKUP;
                    end else begin
                        miss_ready <= 1'b1;
                    end
                end
                ST_LOOKUP: begin
                    ctrl2replace_ready <= 1'b1;
                    state              <= ST_SELECT;
                end
                ST_SELECT: begin
                    victim_way <= replace2ctrl_way;
                    if (replace2ctrl_dirty) begin
                        wb_addr  <= {replace2ctrl_tag, idx_q};
                        wb_valid <= 1'b1;
                        state    <= ST_WB_REQ;
                    end else begin
                        rf_addr  <= {tag_q, idx_q};
                        rf_valid <= 1'b1;
                        state    <= ST_RF_REQ;
                    end
                end
                ST_WB_REQ: begin
                    if (wb_ready) begin
                        wb_valid <= 1'b0;
                        state    <= ST_WB_WAIT;
                    end
                end
                ST_WB_WAIT: begin
                    if (wb_done) begin
                        rf_addr  <= {tag_q, idx_q};
                        rf_valid <= 1'b1;
                        state    <= ST_RF_REQ;
                    end
                end
                ST_RF_REQ: begin
                    if (rf_ready) begin
                        rf_valid <= 1'b0;
                        state    <= ST_RF_WAIT;
                    end
                end
                ST_RF_WAIT: begin
                    if (rf_done) begin
                        tag_we       <= 1'b1;
                        dirty_clr    <= 1'b1;
                        tag_wr_index <= idx_q;
                        tag_wr_way   <= victim_way;
                        tag_wr_tag   <= tag_q;
                        state        <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    done_valid <= 1'b1;
                    done_way   <= victim_way;
                    state      <= ST_DONE;
                end
                ST_DONE: begin
                    // Re-open the miss port only once the completion pulse has been seen.
                    miss_ready <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: begin
                    miss_ready <= 1'b1;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_evict_ctrl.sv
// tb/tb_dcache_evict_ctrl.sv - self-checking bench for dcache_evict_ctrl
module tb_dcache_evict_ctrl;

    localparam int TW = 44;
    localparam int IW = 6;
    typedef logic [383:0] w_t;

    logic              clock = 1'b0;
    logic              reset;
    logic              miss_valid;
    logic              miss_ready;
    logic [IW-1:0]     miss_index;
    logic [TW-1:0]     miss_tag;
    logic [8*TW-1:0]   miss_tag_all;
    logic              done_valid;
    logic [2:0]        done_way;
    logic              ctrl2replace_valid;
    logic [IW-1:0]     ctrl2replace_index;
    logic [8*TW-1:0]   ctrl2replace_tag_all;
    logic              ctrl2replace_ready;
    logic [2:0]        replace2ctrl_way;
    logic              replace2ctrl_dirty;
    logic [TW-1:0]     replace2ctrl_tag;
    logic              wb_valid;
    logic              wb_ready;
    logic [TW+IW-1:0]  wb_addr;
    logic              wb_done;
    logic              rf_valid;
    logic              rf_ready;
    logic [TW+IW-1:0]  rf_addr;
    logic              rf_done;
    logic              tag_we;
    logic [IW-1:0]     tag_wr_index;
    logic [2:0]        tag_wr_way;
    logic [TW-1:0]     tag_wr_tag;
    logic              dirty_clr;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    dcache_evict_ctrl #(.TAG_W(TW), .IDX_W(IW)) dut (
        .clock(clock), .reset(reset),
        .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_index(miss_index),
        .miss_tag(miss_tag), .miss_tag_all(miss_tag_all),
        .done_valid(done_valid), .done_way(done_way),
        .ctrl2replace_valid(ctrl2replace_valid), .ctrl2replace_index(ctrl2replace_index),
        .ctrl2replace_tag_all(ctrl2replace_tag_all), .ctrl2replace_ready(ctrl2replace_ready),
        .replace2ctrl_way(replace2ctrl_way), .replace2ctrl_dirty(replace2ctrl_dirty),
        .replace2ctrl_tag(replace2ctrl_tag),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_done(wb_done),
        .rf_valid(rf_valid), .rf_ready(rf_ready), .rf_addr(rf_addr), .rf_done(rf_done),
        .tag_we(tag_we), .tag_wr_index(tag_wr_index), .tag_wr_way(tag_wr_way),
        .tag_wr_tag(tag_wr_tag), .dirty_clr(dirty_clr)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input w_t obs, input w_t exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
        cyc++;
    endtask

    function automatic logic [TW-1:0] rnd_tag();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[TW-1:0];
    endfunction

    task automatic chk_busy(input string ph);
        chk({ph, "_miss_ready"}, w_t'(miss_ready), w_t'(0));
        chk({ph, "_c2r_valid"}, w_t'(ctrl2replace_valid), w_t'(0));
        chk({ph, "_tag_we"}, w_t'(tag_we), w_t'(0));
        chk({ph, "_done_valid"}, w_t'(done_valid), w_t'(0));
    endtask

    task automatic chk_reset_outs(input string ph);
        chk({ph, "_miss_ready"}, w_t'(miss_ready), w_t'(1));
        chk({ph, "_outs_zero"}, w_t'({done_valid, done_way, ctrl2replace_valid, ctrl2replace_index,
            ctrl2replace_ready, wb_valid, rf_valid, tag_we, tag_wr_index, tag_wr_way, dirty_clr}), w_t'(0));
        chk({ph, "_wb_addr"}, w_t'(wb_addr), w_t'(0));
        chk({ph, "_rf_addr"}, w_t'(rf_addr), w_t'(0));
        chk({ph, "_tag_wr_tag"}, w_t'(tag_wr_tag), w_t'(0));
        chk({ph, "_c2r_tag_all"}, w_t'(ctrl2replace_tag_all), w_t'(0));
    endtask

    // One miss played against the reference protocol: clean misses go straight to refill,
    // dirty ones write the victim {vtag,idx} back first. Latency is counted with the
    // acceptance cycle as cycle 1.
    task automatic run_miss(input logic [IW-1:0] idx, input logic [TW-1:0] tag,
                            input logic [2:0] way, input bit dirty, input logic [TW-1:0] vtag,
                            input int wr, input int wd, input int rr, input int rd,
                            input bit hold, input bit stray, input bit abort);
        logic [8*TW-1:0] tall;
        int acc;
        int waited;
        int exp_lat;
        for (int k = 0; k < 11; k++) tall = {tall[8*TW-33:0], $urandom()};
        waited = 0;
        while (!miss_ready && waited < 20) begin
            step();
            waited++;
        end
        chk("accept_ready", w_t'(miss_ready), w_t'(1));
        miss_valid = 1'b1; miss_index = idx; miss_tag = tag; miss_tag_all = tall;
        acc = cyc;
        step();
        if (!hold) miss_valid = 1'b0;
        chk("lookup_c2r_valid", w_t'(ctrl2replace_valid), w_t'(1));
        chk("lookup_c2r_index", w_t'(ctrl2replace_index), w_t'(idx));
        chk("lookup_c2r_tag_all", w_t'(ctrl2replace_tag_all), w_t'(tall));
        chk("lookup_miss_ready", w_t'(miss_ready), w_t'(0));
        replace2ctrl_way = way; replace2ctrl_dirty = dirty; replace2ctrl_tag = vtag;
        step();
        chk_busy("select");
        chk("select_c2r_ready", w_t'(ctrl2replace_ready), w_t'(1));
        step();
        chk("post_select_c2r_ready", w_t'(ctrl2replace_ready), w_t'(0));
        if (dirty) begin
            chk("wb_valid", w_t'(wb_valid), w_t'(1));
            chk("wb_addr", w_t'(wb_addr), w_t'({vtag, idx}));
            chk("wb_no_rf_valid", w_t'(rf_valid), w_t'(0));
            for (int i = 0; i < wr; i++) begin
                step();
                chk_busy("wb_req");
                chk("wb_valid_held", w_t'(wb_valid), w_t'(1));
                chk("wb_addr_held", w_t'(wb_addr), w_t'({vtag, idx}));
            end
            wb_ready = 1'b1;
            step();
            wb_ready = 1'b0;
            chk("wb_wait_wb_valid", w_t'(wb_valid), w_t'(0));
            for (int i = 0; i < wd; i++) begin
                if (stray && i == 0) rf_done = 1'b1;
                step();
                rf_done = 1'b0;
                chk_busy("wb_wait");
                chk("wb_wait_rf_valid", w_t'({wb_valid, rf_valid}), w_t'(0));
            end
            wb_done = 1'b1;
            step();
            wb_done = 1'b0;
        end else begin
            chk("clean_no_wb_valid", w_t'(wb_valid), w_t'(0));
        end
        chk("rf_valid", w_t'(rf_valid), w_t'(1));
        chk("rf_addr", w_t'(rf_addr), w_t'({tag, idx}));
        for (int i = 0; i < rr; i++) begin
            step();
            chk_busy("rf_req");
            chk("rf_valid_held", w_t'(rf_valid), w_t'(1));
            chk("rf_addr_held", w_t'(rf_addr), w_t'({tag, idx}));
        end
        rf_ready = 1'b1;
        step();
        rf_ready = 1'b0;
        chk("rf_wait_rf_valid", w_t'(rf_valid), w_t'(0));
        if (abort) begin
            reset = 1'b1;
            step();
            reset = 1'b0;
            chk_reset_outs("abort");
            return;
        end
        for (int i = 0; i < rd; i++) begin
            if (stray && i == 0) wb_done = 1'b1;
            step();
            wb_done = 1'b0;
            chk_busy("rf_wait");
            chk("rf_wait_valids", w_t'({wb_valid, rf_valid}), w_t'(0));
        end
        rf_done = 1'b1;
        step();
        rf_done = 1'b0;
        chk("update_strobes", w_t'({tag_we, dirty_clr}), w_t'(2'b11));
        chk("update_index", w_t'(tag_wr_index), w_t'(idx));
        chk("update_way", w_t'(tag_wr_way), w_t'(way));
        chk("update_tag", w_t'(tag_wr_tag), w_t'(tag));
        chk("update_no_done", w_t'(done_valid), w_t'(0));
        step();
        exp_lat = 7 + rr + rd + (dirty ? 2 + wr + wd : 0);
        chk("done_valid", w_t'(done_valid), w_t'(1));
        chk("done_way", w_t'(done_way), w_t'(way));
        chk("done_strobes_low", w_t'({tag_we, dirty_clr}), w_t'(0));
        chk("done_latency", w_t'(cyc - acc + 1), w_t'(exp_lat));
        step();
        chk("idle_done_low", w_t'(done_valid), w_t'(0));
        chk("idle_miss_ready", w_t'(miss_ready), w_t'(1));
    endtask

    initial begin
        reset = 1'b1;
        miss_valid = 1'b0; miss_index = '0; miss_tag = '0; miss_tag_all = '0;
        replace2ctrl_way = '0; replace2ctrl_dirty = 1'b0; replace2ctrl_tag = '0;
        wb_ready = 1'b0; wb_done = 1'b0; rf_ready = 1'b0; rf_done = 1'b0;
        repeat (3) step();
        chk_reset_outs("reset");
        reset = 1'b0;
        step();

        run_miss(6'd5, 44'h123, 3'd3, 1'b0, rnd_tag(), 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        run_miss(6'($urandom_range(0, 63)), rnd_tag(), 3'd7, 1'b1, 44'hABC, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        run_miss(6'($urandom_range(0, 63)), rnd_tag(), 3'd2, 1'b1, rnd_tag(), 10, 2, 10, 3, 1'b0, 1'b1, 1'b0);
        run_miss(6'($urandom_range(0, 63)), rnd_tag(), 3'd4, 1'b1, rnd_tag(), 1, 1, 1, 1, 1'b0, 1'b0, 1'b1);
        run_miss(6'd63, rnd_tag(), 3'd0, 1'b0, rnd_tag(), 0, 0, 2, 1, 1'b0, 1'b0, 1'b0);
        run_miss(6'($urandom_range(0, 63)), rnd_tag(), 3'd1, 1'b1, rnd_tag(), 0, 1, 0, 0, 1'b1, 1'b0, 1'b0);
        run_miss(6'($urandom_range(0, 63)), rnd_tag(), 3'd6, 1'b0, rnd_tag(), 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 20; n++) begin
            run_miss(6'($urandom_range(0, 63)), rnd_tag(), 3'($urandom_range(0, 7)),
                     1'($urandom_range(0, 1)), rnd_tag(),
                     $urandom_range(0, 4), $urandom_range(1, 4),
                     $urandom_range(0, 4), $urandom_range(1, 4),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end
        miss_valid = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
